// File: rtl/rtc_burst_tx.sv
// rtc_burst_tx: captures 8 RTC bytes per frame tick and streams them as an inicioSecuencia-framed burst
module rtc_burst_tx #(
    parameter logic [7:0] ADDR_BASE   = 8'h21,
    parameter int         NUM_SLOTS   = 8,
    parameter int         TAIL_CYCLES = 3,
    parameter int         RD_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       inicioSecuencia,
    output logic [7:0] datoRTC,
    output logic       busy,
    output logic       rd_err,
    output logic       overrun
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PRE, STREAM, TAIL} state_t;

    localparam logic [2:0] LAST_SLOT   = 3'(NUM_SLOTS - 1);
    localparam logic [4:0] LAST_STREAM = 5'(NUM_SLOTS - 1);
    localparam logic [4:0] TAIL_LAST   = 5'(TAIL_CYCLES - 1);
    localparam logic [4:0] TO_LAST     = 5'(RD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] sbuf_q [0:7];
    logic [7:0] sbuf_d [0:7];
    logic       rd_err_q, rd_err_d, overrun_q, overrun_d, rd_req_q, rd_req_d;
    logic       ini_q, ini_d, busy_q, busy_d;
    logic [7:0] rd_addr_q, rd_addr_d, dato_q, dato_d;
    logic       rd_done, rd_to;

    // A read finishes on its data pulse or once the wait budget is used up
    assign rd_to   = cnt_q == TO_LAST;
    assign rd_done = rd_valid || rd_to;

    // State and registered outputs; reset aborts any read or burst in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            cnt_q     <= '0;
            sbuf_q    <= '{default: '0};
            rd_err_q  <= 1'b0;
            overrun_q <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= ADDR_BASE;
            ini_q     <= 1'b0;
            dato_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            sbuf_q    <= sbuf_d;
            rd_err_q  <= rd_err_d;
            overrun_q <= overrun_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            ini_q     <= ini_d;
            dato_q    <= dato_d;
            busy_q    <= busy_d;
        end
    end

    // Next state: RD_REQ holds a request open, RD_WAIT is the one-cycle gap before the next slot; cnt_q is the wait counter, then the stream/tail index
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:    if (tick) begin state_d = RD_REQ; slot_d = '0; end
            RD_REQ:  if (rd_done) begin state_d = (slot_q == LAST_SLOT) ? PRE : RD_WAIT; slot_d = slot_q + 3'd1; end
                     else cnt_d = cnt_q + 5'd1;
            RD_WAIT: state_d = RD_REQ;
            PRE:     state_d = STREAM;
            STREAM:  if (cnt_q == LAST_STREAM) state_d = TAIL; else cnt_d = cnt_q + 5'd1;
            TAIL:    if (cnt_q == TAIL_LAST) state_d = IDLE; else cnt_d = cnt_q + 5'd1;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop
    always_comb begin
        sbuf_d = sbuf_q;
        if (state_q == RD_REQ && rd_done) sbuf_d[slot_q] = rd_valid ? rd_data : 8'hFF;
        rd_err_d  = rd_err_q | (state_q == RD_REQ && !rd_valid && rd_to);
        overrun_d = overrun_q | (tick && state_q != IDLE);
        rd_req_d  = state_d == RD_REQ;
        rd_addr_d = ADDR_BASE + {5'd0, slot_d};
        ini_d     = state_d == PRE || state_d == STREAM || state_d == TAIL;
        dato_d    = (state_d == STREAM) ? sbuf_q[cnt_d[2:0]] : 8'h00;
        busy_d    = state_d != IDLE;
    end

    assign rd_req          = rd_req_q;
    assign rd_addr         = rd_addr_q;
    assign inicioSecuencia = ini_q;
    assign datoRTC         = dato_q;
    assign busy            = busy_q;
    assign rd_err          = rd_err_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_rtc_burst_tx.sv
// tb_rtc_burst_tx: directed scenarios against an RTC read model for rtc_burst_tx
module tb_rtc_burst_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, tick2 = 1'b0;
    logic       rd_req, rd_req2;
    logic [7:0] rd_addr, rd_addr2;
    logic [7:0] rd_data = 8'h00, rd_data2 = 8'h00;
    logic       rd_valid = 1'b0, rd_valid2 = 1'b0;
    logic       ini, ini2, busy, busy2, rd_err, rd_err2, overrun, overrun2;
    logic [7:0] dato, dato2;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:7] = '{8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h21, 8'h05, 8'h06};
    logic [7:0] to_addr = 8'h00;
    logic       spur_en = 1'b0;
    int         age = 0, age2 = 0;
    logic       prev_req = 1'b0, prev_req2 = 1'b0;
    logic [7:0] addr_log[$];
    logic [7:0] wlog[$];

    logic       cap_ok;
    int         cap_len;
    logic [7:0] cap_pre;
    logic [7:0] cap [0:7];

    always #5 clk = ~clk;

    rtc_burst_tx dut (
        .clk(clk), .reset(reset), .tick(tick), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .inicioSecuencia(ini), .datoRTC(dato),
        .busy(busy), .rd_err(rd_err), .overrun(overrun)
    );

    rtc_burst_tx #(.ADDR_BASE(8'hFC)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick2), .rd_req(rd_req2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .inicioSecuencia(ini2), .datoRTC(dato2),
        .busy(busy2), .rd_err(rd_err2), .overrun(overrun2)
    );

    // RTC model: answers two cycles after rd_req rises, never answers to_addr, optional spurious pulses when idle
    always @(negedge clk) begin
        if (rd_req && rd_addr != to_addr) begin
            age = age + 1;
            rd_valid = (age == 2);
            rd_data = (age == 2) ? mem[3'(rd_addr - 8'h21)] : 8'h00;
        end else begin
            age = 0;
            rd_valid = spur_en && !rd_req;
            rd_data = spur_en ? 8'hAA : 8'h00;
        end
        if (rd_req && !prev_req) addr_log.push_back(rd_addr);
        prev_req = rd_req;
    end

    // RTC model for the wrapping instance
    always @(negedge clk) begin
        if (rd_req2) begin
            age2 = age2 + 1;
            rd_valid2 = (age2 == 2);
            rd_data2 = rd_addr2 ^ 8'h5A;
        end else begin
            age2 = 0;
            rd_valid2 = 1'b0;
        end
        if (rd_req2 && !prev_req2) wlog.push_back(rd_addr2);
        prev_req2 = rd_req2;
    end

    task automatic pulse_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic capture();
        cap_ok = 1'b0;
        cap_len = 0;
        for (int i = 0; i < 600 && !cap_ok; i++) begin
            @(negedge clk);
            if (ini) cap_ok = 1'b1;
        end
        checks++;
        if (!cap_ok) begin
            errors++;
            $display("FAIL burst_start: inicioSecuencia never rose within 600 cycles");
        end else begin
            cap_len = 1;
            cap_pre = dato;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                cap[k] = dato;
                if (ini) cap_len++;
            end
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!ini) break;
                cap_len++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
        checks++; if (rd_addr !== 8'h21) begin errors++; $display("FAIL reset_rd_addr got=%h exp=21", rd_addr); end
        checks++; if (ini !== 1'b0 || dato !== 8'h00) begin errors++; $display("FAIL reset_burst got ini=%b dato=%h exp 0/00", ini, dato); end
        checks++; if ({busy, rd_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, rd_err, overrun}); end
        checks++; if (rd_addr2 !== 8'hFC) begin errors++; $display("FAIL reset_wrap_addr got=%h exp=fc", rd_addr2); end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        addr_log.delete();
        pulse_tick();
        capture();
        checks++; if (cap_len !== 12) begin errors++; $display("FAIL nom_len got=%0d exp=12", cap_len); end
        checks++; if (cap_pre !== 8'h00) begin errors++; $display("FAIL nom_pre got=%h exp=00", cap_pre); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap[k] !== mem[k]) begin errors++; $display("FAIL nom_slot%0d got=%h exp=%h", k, cap[k], mem[k]); end
        end
        checks++; if (addr_log.size() !== 8) begin errors++; $display("FAIL nom_nreq got=%0d exp=8", addr_log.size()); end
        for (int k = 0; k < 8 && k < addr_log.size(); k++) begin
            checks++; if (addr_log[k] !== 8'(8'h21 + k)) begin errors++; $display("FAIL nom_addr%0d got=%h exp=%h", k, addr_log[k], 8'(8'h21 + k)); end
        end
        checks++; if (busy !== 1'b0 || dato !== 8'h00) begin errors++; $display("FAIL nom_end got busy=%b dato=%h exp 0/00", busy, dato); end
        checks++; if (rd_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL nom_flags got err=%b ovr=%b exp 0/0", rd_err, overrun); end
    endtask

    task automatic test_timeout();
        to_addr = 8'h24;
        pulse_tick();
        capture();
        to_addr = 8'h00;
        checks++; if (cap_len !== 12) begin errors++; $display("FAIL to_len got=%0d exp=12", cap_len); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap[k] !== ((k == 3) ? 8'hFF : mem[k])) begin
                errors++; $display("FAIL to_slot%0d got=%h exp=%h", k, cap[k], (k == 3) ? 8'hFF : mem[k]);
            end
        end
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", rd_err); end
        pulse_tick();
        capture();
        checks++; if (cap[3] !== mem[3]) begin errors++; $display("FAIL to_clean_slot3 got=%h exp=%h", cap[3], mem[3]); end
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", rd_err); end
    endtask

    task automatic test_overrun();
        addr_log.delete();
        pulse_tick();
        repeat (3) @(negedge clk);
        pulse_tick();
        capture();
        checks++; if (cap_len !== 12) begin errors++; $display("FAIL ovr_len got=%0d exp=12", cap_len); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap[k] !== mem[k]) begin errors++; $display("FAIL ovr_slot%0d got=%h exp=%h", k, cap[k], mem[k]); end
        end
        checks++; if (addr_log.size() !== 8) begin errors++; $display("FAIL ovr_nreq got=%0d exp=8", addr_log.size()); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        pulse_tick();
        capture();
        checks++; if (cap_len !== 12 || cap[7] !== mem[7]) begin errors++; $display("FAIL ovr_next got len=%0d slot7=%h exp 12/%h", cap_len, cap[7], mem[7]); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        pulse_tick();
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (ini) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_start: no burst within 600 cycles"); end
        repeat (5) @(negedge clk);
        checks++; if (dato !== mem[4]) begin errors++; $display("FAIL rmid_slot4 got=%h exp=%h", dato, mem[4]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ini !== 1'b0 || dato !== 8'h00) begin errors++; $display("FAIL rmid_abort got ini=%b dato=%h exp 0/00", ini, dato); end
        checks++; if ({busy, rd_err, overrun, rd_req} !== 4'b0000) begin errors++; $display("FAIL rmid_flags got=%b exp=0000", {busy, rd_err, overrun, rd_req}); end
        @(negedge clk);
        checks++; if (ini !== 1'b0) begin errors++; $display("FAIL rmid_no_resume got ini=%b exp=0", ini); end
        pulse_tick();
        capture();
        checks++; if (cap_len !== 12) begin errors++; $display("FAIL rmid_len got=%0d exp=12", cap_len); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap[k] !== mem[k]) begin errors++; $display("FAIL rmid_slot%0d got=%h exp=%h", k, cap[k], mem[k]); end
        end
    endtask

    task automatic test_spurious();
        @(negedge clk); spur_en = 1'b1;
        repeat (2) @(negedge clk);
        spur_en = 1'b0;
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL spur_idle got busy=%b req=%b exp 0/0", busy, rd_req); end
        pulse_tick();
        capture();
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap[k] !== mem[k]) begin errors++; $display("FAIL spur_slot%0d got=%h exp=%h", k, cap[k], mem[k]); end
        end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL spur_err got=%b exp=0", rd_err); end
    endtask

    task automatic test_wrap();
        bit seen = 1'b0;
        bit done = 1'b0;
        wlog.delete();
        @(negedge clk); tick2 = 1'b1;
        @(negedge clk); tick2 = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (busy2) seen = 1'b1;
            if (seen && !busy2) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL wrap_done: busy never fell within 600 cycles"); end
        checks++; if (wlog.size() !== 8) begin errors++; $display("FAIL wrap_nreq got=%0d exp=8", wlog.size()); end
        for (int k = 0; k < 8 && k < wlog.size(); k++) begin
            checks++; if (wlog[k] !== 8'(8'hFC + k)) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, wlog[k], 8'(8'hFC + k)); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_spurious();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtc_burst_tx.md
Name: rtc_burst_tx

Overview:
- Producer side of the display data-load interface: on each frame tick, reads 8 time/date bytes from the RTC register port into a local buffer.
- Then streams them to the VGA interface block as an inicioSecuencia-framed burst, one byte per clk.
- Sits between the RTC read controller and the display interface; it generates exactly the load sequence the display side latches.

Parameters:
- ADDR_BASE, 8'h21, RTC register address of slot 0; slot k is read from ADDR_BASE+k (8-bit wrap).
- NUM_SLOTS, 8, bytes per burst (fixed at 8; other values unsupported).
- TAIL_CYCLES, 3, cycles inicioSecuencia stays high after the last byte.
- RD_TIMEOUT, 16, max cycles waited for rd_valid per read before substitution.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- tick  in  1  frame-boundary pulse (1 cycle) that starts a capture+burst
- rd_req  out  1  RTC read request, held until rd_valid or timeout
- rd_addr  out  8  RTC register address, stable while rd_req=1
- rd_data  in  8  RTC read data, sampled when rd_valid=1
- rd_valid  in  1  read data valid, 1-cycle pulse
- inicioSecuencia  out  1  burst frame, high for the whole load sequence
- datoRTC  out  8  burst data byte
- busy  out  1  high in any state other than IDLE
- rd_err  out  1  sticky: at least one read timed out; cleared only by reset
- overrun  out  1  sticky: tick arrived while busy; cleared only by reset

Behaviour:
- Reset (sync, at a clk edge with reset=1): state=IDLE. rd_req, inicioSecuencia, busy, rd_err and overrun are 0. rd_addr=ADDR_BASE, datoRTC=0, buffer all 0, counters 0. Reset mid-operation aborts immediately, with no partial burst continuation.
- States: IDLE, RD_REQ, RD_WAIT, PRE, STREAM, TAIL.
- IDLE:
  - tick=1 at edge T -> RD_REQ, with slot=0.
  - rd_req=1 and rd_addr=ADDR_BASE from cycle T+1.
- RD_REQ/RD_WAIT:
  - rd_req stays high and rd_addr=ADDR_BASE+slot. The timeout counter starts at 0 when each request is issued.
  - rd_valid=1: buf[slot]<=rd_data and rd_req drops the next cycle. If slot<7, slot++ and a new request is issued the following cycle (one idle gap cycle); else -> PRE.
  - Counter reaches RD_TIMEOUT without rd_valid: buf[slot]<=8'hFF, rd_err<=1, then advance as for valid.
  - rd_valid while rd_req=0 is ignored.
- PRE: inicioSecuencia=1, datoRTC=0 for exactly 1 cycle.
- STREAM:
  - 8 cycles; in cycle k (k=0..7) datoRTC=buf[k] and inicioSecuencia=1.
  - Slot k appears exactly k+1 cycles after inicioSecuencia rises.
- TAIL: inicioSecuencia=1, datoRTC=0 for TAIL_CYCLES cycles, then -> IDLE.
- Cycle after TAIL ends: inicioSecuencia=0.
- Burst length: inicioSecuencia is high 1+8+TAIL_CYCLES = 12 cycles.
- datoRTC=0 whenever not in STREAM.
- Buffer is written only during the read phase. A burst always transmits the values captured in that same capture. The buffer holds its values after the burst ends.
- tick while busy: ignored (no restart, no queueing) and overrun<=1. A tick on the same edge the FSM returns to IDLE also counts as busy and is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Nominal: reset 2 cycles, tick. RTC model answers each read 2 cycles after rd_req with bytes 24,4,3,23,12,21,5,6 -> rd_addr sequence 21..28h. inicioSecuencia high 12 cycles. datoRTC=24,4,3,23,12,21,5,6 on cycles 1..8 after rise. rd_err=0, busy low after TAIL.
- Timeout: RTC model never asserts rd_valid for slot 3 -> after 16 wait cycles slot 3 is 8'hFF in the burst, other slots correct, rd_err=1 and stays 1 across a second clean burst.
- Overrun: tick again 5 cycles after first tick -> no restart, burst identical to nominal, overrun=1. A tick after busy falls starts a new capture normally.
- Reset mid-burst: assert reset during STREAM slot 4 -> next cycle inicioSecuencia=0, datoRTC=0, busy=0, flags 0. A following tick produces a complete fresh 12-cycle burst.
- Address wrap: ADDR_BASE=8'hFC -> rd_addr sequence FC,FD,FE,FF,00,01,02,03.
- Spurious rd_valid in IDLE with rd_data=8'hAA -> buffer unchanged; next burst shows only requested data.
